// File: rtl/conv_via_tiling_mul_share_arb_if.sv
// conv_via_tiling_mul_share_arb_if: request/response bundle for the shared multiplier.
interface conv_via_tiling_mul_share_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 3,
    parameter int B_WIDTH   = 32,
    parameter int P_WIDTH   = 35,
    parameter int TAG_WIDTH = 8,
    parameter int ID_WIDTH  = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*A_WIDTH-1:0]   req_a;
    logic [NUM_REQ*B_WIDTH-1:0]   req_b;
    logic [NUM_REQ*TAG_WIDTH-1:0] req_tag;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_WIDTH-1:0]          rsp_id;
    logic [TAG_WIDTH-1:0]         rsp_tag;
    logic [P_WIDTH-1:0]           rsp_product;
    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_product
    );
    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_product
    );
endinterface

// File: rtl/conv_via_tiling_mul_share_arb.sv
// conv_via_tiling_mul_share_arb: round-robin sharing of one 3u x 32s multiplier
// with a single registered, back-pressurable response slot.
module mul_3ns_32s_35 #(
    parameter int A_WIDTH = 3,
    parameter int B_WIDTH = 32,
    parameter int P_WIDTH = 35
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] p
);
    assign p = P_WIDTH'($signed({1'b0, a})) * P_WIDTH'($signed(b));
endmodule

module conv_via_tiling_mul_share_arb #(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 3,
    parameter int B_WIDTH   = 32,
    parameter int P_WIDTH   = 35,
    parameter int TAG_WIDTH = 8,
    parameter int ID_WIDTH  = 2
) (
    input logic ap_clk,
    input logic ap_rst_n,
    conv_via_tiling_mul_share_arb_if.slave bus
);
    logic [ID_WIDTH-1:0]  last_grant;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 grant_any;
    logic                 fire;
    logic [A_WIDTH-1:0]   a_sel;
    logic [B_WIDTH-1:0]   b_sel;
    logic [TAG_WIDTH-1:0] tag_sel;
    logic [P_WIDTH-1:0]   product;

    // Descending scan so the nearest index after last_grant is written last and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_id  = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign fire          = (!bus.rsp_valid || bus.rsp_ready) && grant_any;
    assign bus.req_ready = fire ? (NUM_REQ'(1) << grant_id) : '0;
    assign a_sel         = bus.req_a[int'(grant_id)*A_WIDTH +: A_WIDTH];
    assign b_sel         = bus.req_b[int'(grant_id)*B_WIDTH +: B_WIDTH];
    assign tag_sel       = bus.req_tag[int'(grant_id)*TAG_WIDTH +: TAG_WIDTH];

    mul_3ns_32s_35 #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH)) u_mul (
        .a(a_sel),
        .b(b_sel),
        .p(product)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_grant      <= ID_WIDTH'(NUM_REQ - 1);
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= '0;
            bus.rsp_tag     <= '0;
            bus.rsp_product <= '0;
        end else if (fire) begin
            last_grant      <= grant_id;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_id      <= grant_id;
            bus.rsp_tag     <= tag_sel;
            bus.rsp_product <= product;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_via_tiling_mul_share_arb.sv
// tb_conv_via_tiling_mul_share_arb: directed plan cases plus randomized traffic
// checked against a round-robin / exact-product reference model.
module tb_conv_via_tiling_mul_share_arb;
    localparam int N = 4, AW = 3, BW = 32, PW = 35, TW = 8, IW = 2;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    conv_via_tiling_mul_share_arb_if #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW),
        .P_WIDTH(PW), .TAG_WIDTH(TW), .ID_WIDTH(IW)) bus ();

    conv_via_tiling_mul_share_arb #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW),
        .P_WIDTH(PW), .TAG_WIDTH(TW), .ID_WIDTH(IW)) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus(bus)
    );

    logic [AW-1:0] a [N];
    logic [BW-1:0] b [N];
    logic [TW-1:0] t [N];
    logic [N-1:0]  v;
    logic          rr;

    always_comb begin
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.req_tag = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*AW +: AW]   = a[i];
            bus.req_b[i*BW +: BW]   = b[i];
            bus.req_tag[i*TW +: TW] = t[i];
        end
    end
    assign bus.req_valid = v;
    assign bus.rsp_ready = rr;

    int n_cmp = 0, n_bad = 0;
    int m_last;
    bit m_valid;
    int m_id;
    logic [TW-1:0] m_tag;
    longint m_prod;
    int grants[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_last = N - 1; m_id = 0; m_tag = '0; m_prod = 0;
    endfunction

    function automatic int pick();
        if (m_valid && !rr) return -1;
        for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    // One clock: check the grant, let the edge happen, update the model, check the response.
    task automatic step(output int g);
        logic [PW-1:0] p;
        #1;
        g = pick();
        chk("req_ready", 64'(bus.req_ready), g < 0 ? 64'd0 : 64'(1 << g));
        @(posedge ap_clk);
        if (g >= 0) begin
            m_valid = 1; m_id = g; m_tag = t[g]; m_last = g;
            m_prod = longint'(a[g]) * longint'($signed(b[g]));
            grants.push_back(g);
        end else if (rr) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        if (m_valid) begin
            p = bus.rsp_product;
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            chk("rsp_tag", 64'(bus.rsp_tag), 64'(m_tag));
            chk("rsp_product", {{(64-PW){p[PW-1]}}, p}, m_prod);
        end
    endtask

    initial begin
        int g;
        logic [TW-1:0] held_tag;
        logic [PW-1:0] held_prod;
        v = '0; rr = 1'b1;
        for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; t[i] = '0; end
        model_reset();
        #12;
        chk("reset_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_id", 64'(bus.rsp_id), 64'd0);
        chk("reset_tag", 64'(bus.rsp_tag), 64'd0);
        chk("reset_product", 64'(bus.rsp_product), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // single request on requester 0
        v = 4'b0001; a[0] = 3'd7; b[0] = 32'hFFFF_FFFF; t[0] = 8'h11;
        step(g);
        chk("first_grant", 64'(g), 64'd0);
        chk("prod_m7", 64'(bus.rsp_product), 64'h7_FFFF_FFF9);
        v = '0;

        // operand extremes on requester 2
        v = 4'b0100; a[2] = 3'd5; b[2] = 32'h7FFF_FFFF; t[2] = 8'h22;
        step(g);
        chk("prod_max", 64'(bus.rsp_product), 64'h2_7FFF_FFFB);
        a[2] = 3'd4; b[2] = 32'h8000_0000;
        step(g);
        chk("prod_min", 64'(bus.rsp_product), 64'h6_0000_0000);
        a[2] = 3'd0; b[2] = -32'sd123;
        step(g);
        chk("prod_zero", 64'(bus.rsp_product), 64'd0);
        v = '0;
        step(g);

        // all requesters held valid: strict rotation from requester 0
        for (int i = 0; i < N; i++) begin a[i] = AW'(i + 1); b[i] = 32'(i * 1000 - 1500); t[i] = 8'hA0 + 8'(i); end
        // last grant was 2, so move the pointer to 3 first to start rotation at 0
        v = 4'b1000;
        step(g);
        v = 4'b1111;
        grants.delete();
        for (int c = 0; c < 8; c++) begin
            step(g);
            chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
        end
        for (int c = 0; c < 8; c++) chk("rr_order", 64'(grants[c]), 64'(c % N));

        // backpressure with requesters 1 and 3 pending, pointer at 3
        rr = 1'b0; v = 4'b1010;
        held_tag = bus.rsp_tag; held_prod = bus.rsp_product;
        for (int c = 0; c < 3; c++) begin
            step(g);
            chk("bp_tag", 64'(bus.rsp_tag), 64'(held_tag));
            chk("bp_prod", 64'(bus.rsp_product), 64'(held_prod));
        end
        rr = 1'b1;
        step(g);
        chk("bp_next", 64'(g), 64'd1);
        v = '0;
        step(g);

        // single persistent requester 3
        v = 4'b1000;
        grants.delete();
        for (int c = 0; c < 4; c++) begin
            b[3] = $urandom; t[3] = 8'($urandom);
            step(g);
            chk("solo_id", 64'(bus.rsp_id), 64'd3);
        end
        chk("solo_count", 64'(grants.size()), 64'd4);

        // asynchronous reset while a result is pending
        #2 ap_rst_n = 1'b0;
        #1 chk("async_clear", 64'(bus.rsp_valid), 64'd0);
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        v = 4'b1111;
        step(g);
        chk("post_reset_grant", 64'(g), 64'd0);

        // randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            step(g);
            for (int i = 0; i < N; i++) begin
                if (i == g || !v[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    a[i] = AW'($urandom);
                    case ($urandom_range(0, 3))
                        0: b[i] = 32'h8000_0000;
                        1: b[i] = 32'h7FFF_FFFF;
                        default: b[i] = $urandom;
                    endcase
                    t[i] = 8'($urandom);
                end
            end
            rr = ($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_via_tiling_mul_share_arb.md
Name: conv_via_tiling_mul_share_arb

Overview:
Shares one unsigned-3-bit × signed-32-bit multiplier, with a 35-bit signed exact product, between NUM_REQ tiling-loop requesters in the conv_via_tiling datapath. A round-robin arbiter selects one requester per cycle and drives the operands into the combinational multiplier. The product is captured in a single output register with a valid/ready handshake, so one product can be issued per cycle at full throughput.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_WIDTH, 3, unsigned operand width
B_WIDTH, 32, signed operand width
P_WIDTH, 35, product width; must equal A_WIDTH+B_WIDTH
TAG_WIDTH, 8, opaque per-request tag carried to the response
ID_WIDTH, 2, width of requester index; must equal clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_ready  out  NUM_REQ  one-hot grant/accept; combinational
req_a  in  NUM_REQ*A_WIDTH  unsigned operand, requester i at slice [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  signed operand, sliced per requester the same way
req_tag  in  NUM_REQ*TAG_WIDTH  tag, sliced per requester the same way
rsp_valid  out  1  product register holds a valid result
rsp_ready  in  1  downstream accepts the result
rsp_id  out  ID_WIDTH  index of the requester that produced the result
rsp_tag  out  TAG_WIDTH  tag of that request
rsp_product  out  P_WIDTH  signed product

Behaviour:
- Reset (async assert, sync deassert):
  - rsp_valid=0; rsp_id=0; rsp_tag=0; rsp_product=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant:
  - If slot_free and any req_valid is set, grant the first valid index searching cyclically from last_grant+1 (mod NUM_REQ).
  - req_ready[g]=1 for the granted index g only; all other req_ready bits are 0.
  - If !slot_free or no req_valid is set, req_ready=0.
- Transfer on requester i occurs when req_valid[i] && req_ready[i] at a rising edge.
- Requester rule: valid, a, b and tag stay stable until the transfer. Valid must not be dropped early.
- On a transfer at edge N:
  - last_grant<=g.
  - rsp_product<=$signed({1'b0,a_g})*$signed(b_g), full 35 bits, never truncated or saturated.
  - rsp_id<=g; rsp_tag<=tag_g; rsp_valid<=1.
  - The result is visible after edge N, so latency is 1 cycle.
- Output handshake:
  - No transfer and rsp_ready=1: rsp_valid<=0.
  - rsp_valid=1 and rsp_ready=0: hold all rsp_* stable (backpressure). req_ready is 0 in this state.
  - rsp_ready=1 with a new transfer in the same cycle: the register reloads, giving back-to-back 1/cycle throughput.
- last_grant updates only on a transfer. Without one it holds, so the same priority order persists through backpressure.
- A single persistent requester is granted every cycle the slot is free (no forced idle).
- Starvation bound: a continuously valid requester is granted within NUM_REQ transfers.
- Multiplier: instantiated combinational mul_3ns_32s_35 style, with no internal stage. The only pipeline register is the rsp_* register.
- Reset mid-operation: a pending rsp_valid clears immediately and its result is discarded. Arbitration restarts from requester 0.
- rsp_id and rsp_tag are don't-care when rsp_valid=0, but they hold their last value (no X).

Test Plan:
- Reset then single request on req 0, a=7, b=-1, rsp_ready=1 -> req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_product=35'h7_FFFF_FFF9 (-7).
- Extremes on req 2: a=5, b=32'h7FFF_FFFF -> rsp_product=35'h2_7FFF_FFFB. Then a=4, b=32'h8000_0000 -> 35'h6_0000_0000 (-2^33). Then a=0, b=-123 -> 0.
- All 4 req_valid held high, rsp_ready=1, 8 cycles -> grant order 0,1,2,3,0,1,2,3. rsp_valid stays 1 continuously and each rsp_tag matches its requester.
- rsp_ready=0 for 3 cycles while result held, req 1 and req 3 valid -> rsp_* stable, req_ready=0, last_grant unchanged. On rsp_ready=1, the next grant follows the RR order from the held last_grant.
- Only req 3 valid for 4 cycles, rsp_ready=1 -> four consecutive grants to 3, four responses with rsp_id=3.
- Assert ap_rst_n=0 mid-cycle while rsp_valid=1 -> rsp_valid falls immediately without a clock edge. After release with all requesters valid, the first grant goes to req 0.
